// File: rtl/ex_stage_pipe.sv
// ============================================================================
// Module      : ex_stage_pipe
// Description : MIPS execute stage with ID/EX and EX/MEM registers, operand
//               forwarding, immediate extension, ALU, freeze and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_ins,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [4:0]  id_wreg,
  input  logic [2:0]  id_alu_op,
  input  logic        id_alu_in2_chose,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic        mem_valid,
  output logic [31:0] mem_ins,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu_res,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_wreg
);

  localparam logic [2:0] C_OP_ADD = 3'd0;
  localparam logic [2:0] C_OP_SUB = 3'd1;
  localparam logic [2:0] C_OP_OR  = 3'd2;
  localparam logic [2:0] C_OP_LUI = 3'd3;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_ins_q, ex_ins_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_rs_q, ex_rs_d;
  logic [31:0] ex_rt_q, ex_rt_d;
  logic [4:0]  ex_wreg_q, ex_wreg_d;
  logic [2:0]  ex_alu_op_q, ex_alu_op_d;
  logic        ex_in2_q, ex_in2_d;

  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_ins_q, mem_ins_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic [31:0] mem_res_q, mem_res_d;
  logic [31:0] mem_sd_q, mem_sd_d;
  logic [4:0]  mem_wreg_q, mem_wreg_d;

  logic [31:0] w_op_a;
  logic [31:0] w_op_b_reg;
  logic [31:0] w_op_b;
  logic [15:0] w_imm16;
  logic [31:0] w_ext_imm;
  logic [31:0] w_alu_res;

  // ID/EX: flush and invalid slots both load a bubble; hold keeps contents
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ins_d    = ex_ins_q;
    ex_pc_d     = ex_pc_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_wreg_d   = ex_wreg_q;
    ex_alu_op_d = ex_alu_op_q;
    ex_in2_d    = ex_in2_q;
    if (!hold) begin
      if (flush || !id_valid) begin
        ex_valid_d  = 1'b0;
        ex_ins_d    = '0;
        ex_pc_d     = '0;
        ex_rs_d     = '0;
        ex_rt_d     = '0;
        ex_wreg_d   = '0;
        ex_alu_op_d = '0;
        ex_in2_d    = 1'b0;
      end else begin
        ex_valid_d  = 1'b1;
        ex_ins_d    = id_ins;
        ex_pc_d     = id_pc;
        ex_rs_d     = id_rs_val;
        ex_rt_d     = id_rt_val;
        ex_wreg_d   = id_wreg;
        ex_alu_op_d = id_alu_op;
        ex_in2_d    = id_alu_in2_chose;
      end
    end
  end

  always_comb begin
    case (fwd_rs_sel)
      2'd0:    w_op_a = ex_rs_q;
      2'd1:    w_op_a = mem_fwd_data;
      2'd2:    w_op_a = wb_fwd_data;
      default: w_op_a = '0;
    endcase
    case (fwd_rt_sel)
      2'd0:    w_op_b_reg = ex_rt_q;
      2'd1:    w_op_b_reg = mem_fwd_data;
      2'd2:    w_op_b_reg = wb_fwd_data;
      default: w_op_b_reg = '0;
    endcase
  end

  // ori zero-extends its immediate; everything else sign-extends
  assign w_imm16   = ex_ins_q[15:0];
  assign w_ext_imm = (ex_alu_op_q == C_OP_OR) ? {16'h0000, w_imm16}
                                              : {{16{w_imm16[15]}}, w_imm16};
  assign w_op_b    = ex_in2_q ? w_ext_imm : w_op_b_reg;

  always_comb begin
    case (ex_alu_op_q)
      C_OP_ADD: w_alu_res = w_op_a + w_op_b;
      C_OP_SUB: w_alu_res = w_op_a - w_op_b;
      C_OP_OR:  w_alu_res = w_op_a | w_op_b;
      C_OP_LUI: w_alu_res = {w_imm16, 16'h0000};
      default:  w_alu_res = '0;
    endcase
  end

  // EX/MEM: a bubble in EX produces all-zero fields regardless of the buses
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_ins_d   = mem_ins_q;
    mem_pc_d    = mem_pc_q;
    mem_res_d   = mem_res_q;
    mem_sd_d    = mem_sd_q;
    mem_wreg_d  = mem_wreg_q;
    if (!hold) begin
      mem_valid_d = ex_valid_q;
      mem_ins_d   = ex_valid_q ? ex_ins_q   : '0;
      mem_pc_d    = ex_valid_q ? ex_pc_q    : '0;
      mem_res_d   = ex_valid_q ? w_alu_res  : '0;
      mem_sd_d    = ex_valid_q ? w_op_b_reg : '0;
      mem_wreg_d  = ex_valid_q ? ex_wreg_q  : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ins_q    <= '0;
      ex_pc_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_wreg_q   <= '0;
      ex_alu_op_q <= '0;
      ex_in2_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_ins_q   <= '0;
      mem_pc_q    <= '0;
      mem_res_q   <= '0;
      mem_sd_q    <= '0;
      mem_wreg_q  <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ins_q    <= ex_ins_d;
      ex_pc_q     <= ex_pc_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_wreg_q   <= ex_wreg_d;
      ex_alu_op_q <= ex_alu_op_d;
      ex_in2_q    <= ex_in2_d;
      mem_valid_q <= mem_valid_d;
      mem_ins_q   <= mem_ins_d;
      mem_pc_q    <= mem_pc_d;
      mem_res_q   <= mem_res_d;
      mem_sd_q    <= mem_sd_d;
      mem_wreg_q  <= mem_wreg_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_ins        = mem_ins_q;
  assign mem_pc         = mem_pc_q;
  assign mem_alu_res    = mem_res_q;
  assign mem_store_data = mem_sd_q;
  assign mem_wreg       = mem_wreg_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
// ============================================================================
// Module      : tb_ex_stage_pipe
// Description : Directed scoreboard bench for ex_stage_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid;
  logic [31:0] id_ins, id_pc, id_rs_val, id_rt_val;
  logic [4:0]  id_wreg;
  logic [2:0]  id_alu_op;
  logic        id_alu_in2_chose;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        mem_valid;
  logic [31:0] mem_ins, mem_pc, mem_alu_res, mem_store_data;
  logic [4:0]  mem_wreg;

  ex_stage_pipe dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_wreg(id_wreg),
    .id_alu_op(id_alu_op), .id_alu_in2_chose(id_alu_in2_chose),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .mem_valid(mem_valid), .mem_ins(mem_ins), .mem_pc(mem_pc),
    .mem_alu_res(mem_alu_res), .mem_store_data(mem_store_data),
    .mem_wreg(mem_wreg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  wr;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   npass  = 0;
  int   ntotal = 0;

  // forwarding that belongs to the instruction currently sitting in EX
  logic [1:0]  p_fa, p_fb;
  logic [31:0] p_md, p_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'd0, mem_valid}, {31'd0, e.v});
    chk({tag, ".ins"},   mem_ins,        e.ins);
    chk({tag, ".pc"},    mem_pc,         e.pc);
    chk({tag, ".res"},   mem_alu_res,    e.res);
    chk({tag, ".sd"},    mem_store_data, e.sd);
    chk({tag, ".wreg"},  {27'd0, mem_wreg}, {27'd0, e.wr});
  endtask

  function automatic logic [31:0] bsel(input logic [1:0] s, input logic [31:0] rt,
                                       input logic [31:0] md, input logic [31:0] wd);
    case (s)
      2'd0:    bsel = rt;
      2'd1:    bsel = md;
      2'd2:    bsel = wd;
      default: bsel = 32'd0;
    endcase
  endfunction

  task automatic randomize_id();
    id_valid = 1'b1;
    id_ins = $urandom; id_pc = $urandom; id_rs_val = $urandom; id_rt_val = $urandom;
    id_wreg = 5'($urandom_range(1, 31)); id_alu_op = 3'($urandom);
    id_alu_in2_chose = 1'($urandom);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    randomize_id();
    fwd_rs_sel = 2'd1; fwd_rt_sel = 2'd2;
    mem_fwd_data = $urandom; wb_fwd_data = $urandom;
    tick();
    sb.delete();
    last_e = '0;
    check_out(tag, last_e);
    sb.push_back('0);
    p_fa = 2'd0; p_fb = 2'd0; p_md = 32'd0; p_wd = 32'd0;
  endtask

  // one advancing edge: ID slot enters ID/EX, EX result lands in EX/MEM
  task automatic issue(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] wr, input logic [2:0] op, input logic in2,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] md, input logic [31:0] wd,
                       input logic [31:0] res, input logic fl);
    exp_t e;
    reset = 1'b0; hold = 1'b0; flush = fl;
    id_valid = v; id_ins = ins; id_pc = pc; id_rs_val = rs; id_rt_val = rt;
    id_wreg = wr; id_alu_op = op; id_alu_in2_chose = in2;
    fwd_rs_sel = p_fa; fwd_rt_sel = p_fb; mem_fwd_data = p_md; wb_fwd_data = p_wd;
    if (v && !fl) e = '{1'b1, ins, pc, res, bsel(fb, rt, md, wd), wr};
    else          e = '0;
    sb.push_back(e);
    tick();
    last_e = sb.pop_front();
    check_out(tag, last_e);
    if (v && !fl) begin
      p_fa = fa; p_fb = fb; p_md = md; p_wd = wd;
    end else begin
      p_fa = 2'($urandom); p_fb = 2'($urandom); p_md = $urandom; p_wd = $urandom;
    end
  endtask

  task automatic hold_cycle(input string tag, input logic fl);
    reset = 1'b0; hold = 1'b1; flush = fl;
    randomize_id();
    fwd_rs_sel = 2'($urandom); fwd_rt_sel = 2'($urandom);
    mem_fwd_data = $urandom; wb_fwd_data = $urandom;
    tick();
    check_out(tag, last_e);
  endtask

  initial begin
    do_reset("rst0");
    do_reset("rst1");

    // first instruction after release appears exactly two edges later
    issue("addu", 1, 32'h00A6_1021, 32'h0000_0100, 32'h5, 32'hFFFF_FFFF, 5'd2, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0004, 0);
    issue("subu", 1, 32'h00A6_1823, 32'h0000_0104, 32'h5, 32'hFFFF_FFFF, 5'd3, 3'd1, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0006, 0);
    issue("ori",  1, 32'h34A4_8001, 32'h0000_0108, 32'h5, 32'hFFFF_FFFF, 5'd4, 3'd2, 1,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_8005, 0);
    issue("lui",  1, 32'h3C05_1234, 32'h0000_010C, 32'h5, 32'hFFFF_FFFF, 5'd5, 3'd3, 1,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h1234_0000, 0);
    issue("lw",   1, 32'h8C46_FFFC, 32'h0000_0110, 32'h1000, 32'h0, 5'd6, 3'd0, 1,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0FFC, 0);
    issue("sw",   1, 32'hAC47_0004, 32'h0000_0114, 32'h1000, 32'hDEAD_BEEF, 5'd0, 3'd0, 1,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_1004, 0);
    issue("fwd",  1, 32'h0128_5021, 32'h0000_0118, 32'hAAAA, 32'hBBBB, 5'd10, 3'd0, 0,
          2'd1, 2'd2, 32'h10, 32'h3, 32'h0000_0013, 0);
    issue("fwdz", 1, 32'h0128_5821, 32'h0000_011C, 32'hAAAA, 32'h77, 5'd11, 3'd0, 0,
          2'd3, 2'd0, 32'h99, 32'h88, 32'h0000_0077, 0);

    hold_cycle("hold0", 0);
    hold_cycle("hold1", 0);
    hold_cycle("hold2", 0);
    issue("rel0", 1, 32'h0000_0000, 32'h0000_0120, 32'h7, 32'h9, 5'd12, 3'd1, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 0);
    issue("rel1", 1, 32'h0000_0003, 32'h0000_0124, 32'h20, 32'h1, 5'd13, 3'd0, 1,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0023, 0);

    issue("flsh", 1, 32'h1111_1111, 32'h0000_0128, 32'h1, 32'h1, 5'd14, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0002, 1);
    issue("aft0", 1, 32'h0000_0010, 32'h0000_012C, 32'h1, 32'h2, 5'd15, 3'd2, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0003, 0);

    hold_cycle("hf0", 1);
    issue("aft1", 1, 32'h0000_0020, 32'h0000_0130, 32'h40, 32'h2, 5'd16, 3'd5, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0000, 0);
    issue("inv",  0, 32'h1234_5678, 32'h0000_0134, 32'h1, 32'h2, 5'd7, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
    issue("ori2", 1, 32'h3400_00F0, 32'h0000_0138, 32'h0F, 32'h0, 5'd17, 3'd2, 1,
          2'd2, 2'd1, 32'h5, 32'h100, 32'h0000_01F0, 0);
    issue("drn0", 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
    issue("drn1", 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);

    // reset in the middle of a stream drops everything in flight
    issue("pre",  1, 32'h0000_0001, 32'h0000_0200, 32'h3, 32'h4, 5'd18, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0000_0007, 0);
    do_reset("rstm");
    issue("post", 1, 32'h0000_0002, 32'h0000_0204, 32'h3, 32'h4, 5'd19, 3'd1, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
    issue("post1", 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 0,
          2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

- Execute stage of the five-stage MIPS pipeline, on the consuming side of the EX-stage control decoder.
- Captures decoded ID-stage state into an ID/EX register, then applies operand forwarding.
- Extends the immediate and evaluates the ALU using the decoder's `alu_op` / `alu_in2_chose` encoding.
- Registers the result into EX/MEM for the memory stage. Supports pipeline freeze and ID/EX flush (bubble insertion).

## Interface

Parameters: none.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high. Clears both pipeline registers to bubble.
- `hold` in 1: freeze both ID/EX and EX/MEM registers.
- `flush` in 1: load a bubble into ID/EX at the next edge.
- `id_valid` in 1: ID-stage slot holds a real instruction.
- `id_ins` in 32: instruction word.
- `id_pc` in 32: instruction address.
- `id_rs_val` in 32: register-file rs read value.
- `id_rt_val` in 32: register-file rt read value.
- `id_wreg` in 5: destination register number (0 = no write).
- `id_alu_op` in 3: 0 add, 1 sub, 2 or, 3 lui, 4–7 reserved.
- `id_alu_in2_chose` in 1: 0 = operand B is rt, 1 = operand B is the extended immediate.
- `fwd_rs_sel` in 2, `fwd_rt_sel` in 2: operand source. 0 = ID/EX copy, 1 = `mem_fwd_data`, 2 = `wb_fwd_data`, 3 = zero.
- `mem_fwd_data` in 32, `wb_fwd_data` in 32: forwarding buses from later stages.
- `mem_valid` out 1, `mem_ins` out 32, `mem_pc` out 32: EX/MEM copies.
- `mem_alu_res` out 32: ALU result.
- `mem_store_data` out 32: forwarded rt, used by sw.
- `mem_wreg` out 5: destination register.

## Operation

- **ID/EX capture:** captures `id_*` fields, including `id_alu_op`, `id_alu_in2_chose`, and `imm16 = id_ins[15:0]`.
- **Operand forwarding:** operand A = mux(`fwd_rs_sel`), operand B_reg = mux(`fwd_rt_sel`). Both muxes are evaluated combinationally in EX from the current forwarding buses.
- **Immediate extension:** `alu_op == 2` → zero-extend; otherwise sign-extend from bit 15.
- **Operand B:** `alu_in2_chose` ? ext_imm : B_reg.
- **ALU, all arithmetic mod 2^32, no overflow trap:**
  - op0: A + B
  - op1: A − B
  - op2: A | B
  - op3: {imm16, 16'h0000}, with A ignored
  - op4–7: 0
- **Store data:** `mem_store_data` is always B_reg, regardless of `alu_in2_chose`.
- **Bubble:** valid = 0, ins = 0, pc = 0, wreg = 0, all data fields = 0. Both registers hold a bubble when a bubble is in EX.
- **Invalid slots:** an invalid (`valid = 0`) slot passes through unchanged as a bubble. `mem_wreg` is forced to 0 whenever valid = 0.
- **Priority per edge:** `reset` > `hold` > `flush` > normal advance.
  - `hold`: both registers keep their value. `flush` is ignored that cycle and must be reasserted by the hazard unit if still needed.
  - `flush` without `hold`: ID/EX ← bubble, while EX/MEM still captures the current EX result.
- **Reset values:** all outputs 0, `mem_valid` = 0.

## Timing

- **Latency:** ID inputs present before edge N reach ID/EX at N. The result is visible on `mem_*` after edge N+1, i.e. 2 edges of latency. Throughput is one instruction per cycle.
- **Forwarding sample point:** forwarding selects and buses are sampled at the edge that loads EX/MEM, not at ID/EX capture.
- **During `hold`:** `mem_*` outputs are stable. Forwarding inputs may change freely; the captured result is unaffected until release.
- **Reset timing:** reset asserted mid-stream clears in-flight instructions on that edge. Outputs read 0 from the following cycle.
- **Release from reset:** the first valid instruction appears on `mem_*` 2 edges after release.
- **Combinational paths:** no combinational path from any input to any output.

## Test plan

- **Reset:** assert `reset` with non-zero ID inputs for 2 cycles → all `mem_*` = 0, `mem_valid` = 0. The first instruction after release appears exactly 2 edges later.
- **Back-to-back ALU ops:** issue 4 instructions on consecutive cycles, with rs = 0x0000_0005, rt = 0xFFFF_FFFF.
  - addu → 0x0000_0004
  - subu → 0x0000_0006
  - ori imm 0x8001, `alu_in2_chose` = 1 → 0x0000_8005 (zero-extend)
  - lui imm 0x1234 → 0x1234_0000
- **Address calculation and store data:** lw with rs = 0x0000_1000, imm 0xFFFC (op0, sel 1) → `mem_alu_res` = 0x0000_0FFC (sign-extend). A following sw with rt = 0xDEAD_BEEF → `mem_store_data` = 0xDEAD_BEEF.
- **Forwarding:** `fwd_rs_sel` = 1 with `mem_fwd_data` = 0x10, `fwd_rt_sel` = 2 with `wb_fwd_data` = 0x3, addu → 0x13. `fwd_rs_sel` = 3 → result equals B.
- **Hold/flush interplay:**
  - Assert `hold` 3 cycles mid-stream → `mem_*` frozen, no instruction lost or duplicated after release.
  - `flush` alone → exactly one bubble (`mem_valid` = 0) appears one edge later.
  - `hold` + `flush` together → behaves as hold only.
- **Reserved op and invalid slot:** `alu_op` = 5 → `mem_alu_res` = 0. `id_valid` = 0 with `id_wreg` = 7 → `mem_wreg` = 0, `mem_valid` = 0.
